// File: rtl/word_pack_pkg.sv
// Shared field layout and state encoding for the 32-bit word packer and slicer.
// The tag placement constants keep both sides decoding the same bit fields.
package word_pack_pkg;

  localparam int HALF_W_DEF  = 16;
  localparam int TAG_W_DEF   = 4;
  localparam int CNT_W_DEF   = 8;

  localparam int TAG_LSB     = 1;
  localparam int ALT_TAG_LSB = 9;

  typedef enum logic {
    S_HI = 1'b0,
    S_LO = 1'b1
  } pack_state_e;

endpackage

// File: rtl/word_out_reg.sv
// Output word register with valid/ready hold logic and a wrapping count of
// completed output handshakes.
module word_out_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  cnt_o
);

  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_drain;

  assign w_drain = r_valid && ready_i;

  // A reload in the same cycle as a drain keeps the word valid.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_data  <= {DATA_W{1'b0}};
      r_valid <= 1'b0;
      r_cnt   <= {CNT_W{1'b0}};
    end else begin
      if (load_i) begin
        r_data <= data_i;
      end else begin
        r_data <= r_data;
      end
      r_valid <= load_i || (r_valid && !ready_i);
      if (w_drain) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  assign valid_o = r_valid;
  assign data_o  = r_data;
  assign cnt_o   = r_cnt;

endmodule

// File: rtl/word_packer.sv
// Packs an upper and a lower half-word plus a tag into one word; the tag lands
// in the primary field, and a zero tag may also clear the alternate field.
module word_packer
  import word_pack_pkg::*;
#(
  parameter int HALF_W = HALF_W_DEF,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                half_valid_i,
  output logic                half_ready_o,
  input  logic [HALF_W-1:0]   half_i,
  input  logic [TAG_W-1:0]    tag_i,
  input  logic                sel_i,
  output logic                word_valid_o,
  input  logic                word_ready_i,
  output logic [2*HALF_W-1:0] data_o,
  output logic [CNT_W-1:0]    word_cnt_o
);

  pack_state_e         r_state;
  pack_state_e         w_state_nxt;
  logic [HALF_W-1:0]   r_hi;
  logic [HALF_W-1:0]   w_hi_nxt;
  logic [HALF_W-1:0]   w_lo;
  logic                w_half_ready;
  logic                w_in_xfer;
  logic                w_lo_load;
  logic                w_word_valid;
  logic [2*HALF_W-1:0] w_word;

  // The lower half may only enter once the output register is free or draining.
  always_comb begin
    w_half_ready = 1'b0;
    if (!rst_ni || flush_i) begin
      w_half_ready = 1'b0;
    end else begin
      case (r_state)
        S_HI:    w_half_ready = 1'b1;
        S_LO:    w_half_ready = !w_word_valid || word_ready_i;
        default: w_half_ready = 1'b0;
      endcase
    end
  end

  assign w_in_xfer = half_valid_i && w_half_ready;

  // Flush takes priority and abandons any stored upper half.
  always_comb begin
    w_state_nxt = r_state;
    w_hi_nxt    = r_hi;
    w_lo_load   = 1'b0;
    if (flush_i) begin
      w_state_nxt = S_HI;
      w_hi_nxt    = {HALF_W{1'b0}};
    end else if (w_in_xfer) begin
      case (r_state)
        S_HI: begin
          w_hi_nxt    = half_i;
          w_state_nxt = S_LO;
        end
        S_LO: begin
          w_lo_load   = 1'b1;
          w_state_nxt = S_HI;
        end
        default: begin
          w_state_nxt = S_HI;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // A zero tag in alternate mode is signalled through the alternate field too.
  always_comb begin
    w_lo = half_i;
    w_lo[TAG_LSB +: TAG_W] = tag_i;
    if (sel_i && (tag_i == {TAG_W{1'b0}})) begin
      w_lo[ALT_TAG_LSB +: TAG_W] = {TAG_W{1'b0}};
    end else begin
      w_lo[ALT_TAG_LSB +: TAG_W] = w_lo[ALT_TAG_LSB +: TAG_W];
    end
  end

  assign w_word = {r_hi, w_lo};

  // Assembly state and stored upper half.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= S_HI;
      r_hi    <= {HALF_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_hi    <= w_hi_nxt;
    end
  end

  word_out_reg #(
    .DATA_W (2*HALF_W),
    .CNT_W  (CNT_W)
  ) u_out (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (w_lo_load),
    .data_i  (w_word),
    .ready_i (word_ready_i),
    .valid_o (w_word_valid),
    .data_o  (data_o),
    .cnt_o   (word_cnt_o)
  );

  assign half_ready_o = w_half_ready;
  assign word_valid_o = w_word_valid;

endmodule

// File: tb/tb_word_packer.sv
// Directed and randomized checks of word_packer against a queue-based
// reference model of the half-word assembly and word delivery rules.
module tb_word_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        hv;
  logic        half_ready;
  logic [15:0] half;
  logic [3:0]  tag;
  logic        sel;
  logic        word_valid;
  logic        wr;
  logic [31:0] data;
  logic [7:0]  cnt;

  int n_tests = 0;
  int n_fail  = 0;

  bit          m_have_hi;
  logic [15:0] m_hi;
  logic [31:0] m_word;
  bit          m_full;
  logic [7:0]  m_cnt;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [31:0] saved;

  always #5 clk = ~clk;

  word_packer dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (flush),
    .half_valid_i (hv),
    .half_ready_o (half_ready),
    .half_i       (half),
    .tag_i        (tag),
    .sel_i        (sel),
    .word_valid_o (word_valid),
    .word_ready_i (wr),
    .data_o       (data),
    .word_cnt_o   (cnt)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic [15:0] hi, input logic [15:0] lo,
                                       input logic [3:0] t, input bit s);
    logic [15:0] l;
    l = (lo & 16'hFFE1) | (16'(t) << 1);
    if (s && t == 4'd0) l = l & 16'hE1FF;
    return {hi, l};
  endfunction

  task automatic cycle();
    logic exp_rdy;
    bit   in_x;
    bit   out_x;
    #3;
    exp_rdy = rst_n && !flush && (!m_have_hi || !m_full || wr);
    chk("half_ready", {31'd0, half_ready}, {31'd0, exp_rdy});
    in_x  = hv && exp_rdy;
    out_x = rst_n && m_full && wr;
    if (rst_n && word_valid && wr) got_q.push_back(data);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_have_hi = 0; m_hi = 16'd0; m_word = 32'd0; m_full = 0; m_cnt = 8'd0;
    end else begin
      if (flush) m_have_hi = 0;
      if (out_x) begin
        exp_q.push_back(m_word);
        m_full = 0;
        m_cnt  = m_cnt + 8'd1;
      end
      if (in_x) begin
        if (!m_have_hi) begin
          m_hi = half; m_have_hi = 1;
        end else begin
          m_word = pack(m_hi, half, tag, sel); m_full = 1; m_have_hi = 0;
        end
      end
    end
    chk("word_valid", {31'd0, word_valid}, {31'd0, m_full});
    chk("data", data, m_word);
    chk("word_cnt", {24'd0, cnt}, {24'd0, m_cnt});
  endtask

  task automatic drv(input bit v, input logic [15:0] h, input logic [3:0] t,
                     input bit s, input bit r, input bit f);
    hv = v; half = h; tag = t; sel = s; wr = r; flush = f;
    cycle();
  endtask

  initial begin
    m_have_hi = 0; m_hi = 16'd0; m_word = 32'd0; m_full = 0; m_cnt = 8'd0;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) drv(1'b1, 16'h1111, 4'h0, 1'b0, 1'b1, 1'b0);
    chk("reset_valid", {31'd0, word_valid}, 32'd0);
    chk("reset_data", data, 32'd0);
    rst_n = 1'b1;

    // basic packing
    drv(1'b1, 16'hDEAD, 4'h0, 1'b0, 1'b1, 1'b0);
    drv(1'b1, 16'hBEE1, 4'hA, 1'b0, 1'b1, 1'b0);
    chk("basic_word", data, 32'hDEADBEF5);
    chk("basic_cnt0", {24'd0, cnt}, 32'd0);
    drv(1'b0, 16'h0000, 4'h0, 1'b0, 1'b1, 1'b0);
    chk("basic_cnt1", {24'd0, cnt}, 32'd1);

    // alternate tag field
    drv(1'b1, 16'h1234, 4'h0, 1'b0, 1'b1, 1'b0);
    drv(1'b1, 16'hFFFF, 4'h0, 1'b1, 1'b1, 1'b0);
    chk("alt_tag0", {16'd0, data[15:0]}, 32'h0000E1E1);
    drv(1'b1, 16'h5678, 4'h0, 1'b0, 1'b1, 1'b0);
    drv(1'b1, 16'hFFFF, 4'h3, 1'b1, 1'b1, 1'b0);
    chk("alt_tag3", {16'd0, data[15:0]}, 32'h0000FFE7);
    drv(1'b0, 16'h0000, 4'h0, 1'b0, 1'b1, 1'b0);

    // back-pressure with continuous input
    drv(1'b1, 16'hA0A0, 4'h0, 1'b0, 1'b0, 1'b0);
    drv(1'b1, 16'hA1A1, 4'h5, 1'b0, 1'b0, 1'b0);
    saved = data;
    for (int i = 0; i < 5; i++)
      drv(1'b1, 16'($urandom), 4'($urandom), 1'($urandom), 1'b0, 1'b0);
    chk("stall_stable", data, saved);
    chk("stall_ready", {31'd0, half_ready}, 32'd0);
    drv(1'b1, 16'hB2B2, 4'h6, 1'b0, 1'b1, 1'b0);
    drv(1'b0, 16'h0000, 4'h0, 1'b0, 1'b1, 1'b0);

    // flush alongside the lower half with a pending output word
    drv(1'b1, 16'hC0C0, 4'h0, 1'b0, 1'b0, 1'b0);
    drv(1'b1, 16'hC1C1, 4'h2, 1'b0, 1'b0, 1'b0);
    drv(1'b1, 16'hD0D0, 4'h0, 1'b0, 1'b0, 1'b0);
    drv(1'b1, 16'hD1D1, 4'h4, 1'b0, 1'b1, 1'b1);
    drv(1'b1, 16'hE0E0, 4'h0, 1'b0, 1'b1, 1'b0);
    drv(1'b1, 16'hE1E1, 4'h9, 1'b0, 1'b1, 1'b0);
    chk("post_flush_word", data, 32'hE0E0E1F3);
    drv(1'b0, 16'h0000, 4'h0, 1'b0, 1'b1, 1'b0);

    // reset while a word is pending and an upper half is stored
    drv(1'b1, 16'h1010, 4'h0, 1'b0, 1'b0, 1'b0);
    drv(1'b1, 16'h2020, 4'h1, 1'b0, 1'b0, 1'b0);
    drv(1'b1, 16'h3030, 4'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    drv(1'b1, 16'h4040, 4'h7, 1'b0, 1'b1, 1'b0);
    chk("rst_mid_valid", {31'd0, word_valid}, 32'd0);
    chk("rst_mid_data", data, 32'd0);
    chk("rst_mid_cnt", {24'd0, cnt}, 32'd0);
    rst_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 400; i++)
      drv(1'($urandom), 16'($urandom), 4'($urandom), 1'($urandom),
          1'($urandom), ($urandom_range(0, 15) == 0));
    drv(1'b0, 16'h0000, 4'h0, 1'b0, 1'b1, 1'b0);

    // counter wrap at full throughput from reset
    rst_n = 1'b0;
    drv(1'b0, 16'h0000, 4'h0, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 513; i++)
      drv(1'b1, 16'($urandom), 4'($urandom), 1'($urandom), 1'b1, 1'b0);
    chk("cnt_wrap", {24'd0, cnt}, 32'd0);
    drv(1'b0, 16'h0000, 4'h0, 1'b0, 1'b1, 1'b0);
    drv(1'b0, 16'h0000, 4'h0, 1'b0, 1'b1, 1'b0);

    chk("delivered_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk("delivered_word", got_q[i], exp_q[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/word_packer.md
# word_packer

Assembles two 16-bit half-words and a 4-bit tag into one 32-bit word, the transmit-side counterpart of the 32-bit slicing stage: a 32-bit word produced here slices back to the same upper half and tag. Upstream pushes halves (upper first) over a valid/ready handshake. Downstream drains completed words over a second valid/ready handshake. A registered output stage lets the block sustain one word every two cycles.

## Interface
Parameters:
- `HALF_W`, 16, half-word width; the packed word is 2*HALF_W.
- `TAG_W`, 4, tag width.
- `CNT_W`, 8, width of the emitted-word counter.

Ports:
- `clk_i`  in  1  clock; all logic on its rising edge.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `flush_i`  in  1  discards a partially assembled word.
- `half_valid_i`  in  1  `half_i` / `tag_i` / `sel_i` are valid.
- `half_ready_o`  out  1  block accepts a half this cycle.
- `half_i`  in  HALF_W  half-word; upper half first, then lower half.
- `tag_i`  in  TAG_W  tag; sampled only with the lower half.
- `sel_i`  in  1  tag placement mode; sampled only with the lower half.
- `word_valid_o`  out  1  `data_o` holds a completed word.
- `word_ready_i`  in  1  downstream accepts the word.
- `data_o`  out  2*HALF_W  packed word.
- `word_cnt_o`  out  CNT_W  count of completed output handshakes.

## Operation
- Assembly FSM states:
  - `S_HI`: waiting for the upper half.
  - `S_LO`: upper half stored, waiting for the lower half.
- Transfers:
  - An input transfer is `half_valid_i && half_ready_o`.
  - An output transfer is `word_valid_o && word_ready_i`.
- `S_HI` behaviour:
  - `half_ready_o` = 1.
  - On transfer: store `half_i` as `hi_q` and go to `S_LO`.
- `S_LO` behaviour:
  - `half_ready_o` = `!word_valid_o || word_ready_i`, so the output register is free or draining this cycle.
  - On transfer: load the output register and go to `S_HI`.
- Word format:
  - `data_o[31:16]` = `hi_q`.
  - `data_o[15:0]` = `half_i`, then bits [4:1] are overwritten with `tag_i`.
  - If `sel_i`=1 and `tag_i`=0, bits [12:9] are also forced to 0. The receiving slicer then decodes a tag of 0 from the alternate field.
  - If `sel_i`=0, only [4:1] is overwritten.
- Flush:
  - `flush_i`=1 forces the FSM to `S_HI`, discards `hi_q`, and drives `half_ready_o`=0 that cycle. Flush wins over a simultaneous input transfer.
  - The output register, `word_valid_o` and `word_cnt_o` are unaffected by flush.
- Output register:
  - `word_valid_o` sets on lower-half acceptance.
  - It clears on an output transfer with no new lower half in the same cycle.
  - If a new lower half arrives in the same cycle as an output transfer, the register reloads and `word_valid_o` stays 1.
- Counter: `word_cnt_o` increments by 1 per output transfer and wraps from 2^CNT_W-1 to 0.

## Timing
- Reset (`rst_ni`=0 at a clock edge):
  - FSM goes to `S_HI`; `hi_q`=0, `data_o`=0, `word_valid_o`=0, `word_cnt_o`=0.
  - While `rst_ni`=0, `half_ready_o` is driven 0.
  - Reset mid-word drops both the partial word and any undelivered output word.
- Latency: lower half accepted at edge N, so `word_valid_o`=1 and `data_o` are valid from edge N through the cycle after it.
- Stall: `data_o` and `word_valid_o` are held stable while `word_valid_o && !word_ready_i`. The upper half of the next word is still accepted; the lower half is stalled.
- Throughput: with `half_valid_i` and `word_ready_i` held high, one word every 2 cycles and no bubbles.
- `half_ready_o` is combinational from state, `word_valid_o`, `word_ready_i`, `flush_i` and `rst_ni`. There is no path from `half_valid_i` to `half_ready_o`.
- `word_ready_i` may toggle freely. A word is delivered exactly once.

## Structure
- Package `word_pack_pkg` holds:
  - constants `TAG_LSB`=1 and `ALT_TAG_LSB`=9;
  - default widths;
  - `typedef enum logic {S_HI, S_LO} pack_state_e`.
- The package is shared with the slicing side so field positions stay in one place.
- One sub-module, `word_out_reg`: the output data register with its valid/ready hold logic and the counter. The FSM and field insertion stay in `word_packer`.

## Test plan
- Basic packing: halves 0xDEAD then 0xBEE1, `tag_i`=0xA, `sel_i`=0 → `data_o`=0xDEADBEF5 one cycle after the lower half; `word_cnt_o` goes 0→1.
- Alternate field: `sel_i`=1, `tag_i`=0, lower half 0xFFFF → `data_o[15:0]`=0xE1E1. With `tag_i`=0x3 the lower half is 0xFFE7.
- Back-pressure: `word_ready_i`=0 for 5 cycles with continuous input → `data_o` is stable, the next upper half is accepted, `half_ready_o`=0 in `S_LO`. Releasing `word_ready_i` delivers both words in order with no loss or duplication.
- Flush: `flush_i` asserted together with the lower half → no word is produced and the FSM is in `S_HI`. The next pair of halves packs correctly, and a pending output word is still delivered.
- Reset mid-operation: `rst_ni`=0 while in `S_LO` with `word_valid_o`=1 → all outputs are 0 the next cycle and `half_ready_o`=0 during reset.
- Counter wrap: 256 words → `word_cnt_o` returns to 0.
